pipe_stage_reg: RTL and testbench

//  Generic parametrised pipeline stage register for IF/ID, ID/EX, EX/MEM, MEM/WB boundaries.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_stage_reg.sv | 136 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy states, payload widths
// and the per-boundary control encodings loaded into bubbles.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    localparam int PIPE_DATA_W = 160;
    localparam int PIPE_CTRL_W = 16;

    // All-zero control decodes to no register write and no memory access at every boundary
    localparam logic [PIPE_CTRL_W-1:0] CTRL_NOP_IFID  = '0;
    localparam logic [PIPE_CTRL_W-1:0] CTRL_NOP_IDEX  = '0;
    localparam logic [PIPE_CTRL_W-1:0] CTRL_NOP_EXMEM = '0;
    localparam logic [PIPE_CTRL_W-1:0] CTRL_NOP_MEMWB = '0;

    function automatic logic [1:0] occ_count(input occ_state_e s);
        case (s)
            OCC_ONE:  return 2'd1;
            OCC_FULL: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and an optional
// 2-entry skid buffer that keeps the upstream ready path registered.
//
//  state     | meaning
//  OCC_EMPTY | no entry held; outputs show a bubble
//  OCC_ONE   | main slot holds the oldest entry
//  OCC_FULL  | main and skid both hold entries (SKID=1 only); input stalled
import pipe_pkg::*;

module pipe_stage_reg #(
    parameter int                 DATA_W   = PIPE_DATA_W,
    parameter int                 CTRL_W   = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
    parameter int                 SKID     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occ
);

    occ_state_e        r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              r_in_ready;

    occ_state_e        w_state_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [CTRL_W-1:0] w_main_ctrl_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;
    logic              w_in_ready;
    logic              w_in_ready_nxt;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_out_valid;

    always_comb begin
        w_out_valid     = (r_state != OCC_EMPTY);
        // Without the skid slot, a held entry leaving this cycle frees the only slot
        w_in_ready      = (SKID != 0) ? r_in_ready : (!w_out_valid || out_ready);
        w_in_fire       = in_valid && w_in_ready;
        w_out_fire      = w_out_valid && out_ready;

        w_state_nxt     = r_state;
        w_main_data_nxt = r_main_data;
        w_main_ctrl_nxt = r_main_ctrl;
        w_skid_data_nxt = r_skid_data;
        w_skid_ctrl_nxt = r_skid_ctrl;

        if (flush) begin
            w_state_nxt     = OCC_EMPTY;
            w_main_data_nxt = '0;
            w_main_ctrl_nxt = CTRL_NOP;
            w_skid_data_nxt = '0;
            w_skid_ctrl_nxt = CTRL_NOP;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt     = OCC_ONE;
                        w_main_data_nxt = in_data;
                        w_main_ctrl_nxt = in_ctrl;
                    end
                end
                OCC_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_data_nxt = in_data;
                        w_main_ctrl_nxt = in_ctrl;
                    end else if (w_in_fire && (SKID != 0)) begin
                        w_state_nxt     = OCC_FULL;
                        w_skid_data_nxt = in_data;
                        w_skid_ctrl_nxt = in_ctrl;
                    end else if (w_out_fire) begin
                        w_state_nxt     = OCC_EMPTY;
                        w_main_data_nxt = '0;
                        w_main_ctrl_nxt = CTRL_NOP;
                    end
                end
                OCC_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt     = OCC_ONE;
                        w_main_data_nxt = r_skid_data;
                        w_main_ctrl_nxt = r_skid_ctrl;
                        w_skid_data_nxt = '0;
                        w_skid_ctrl_nxt = CTRL_NOP;
                    end
                end
                default: begin
                    w_state_nxt     = OCC_EMPTY;
                    w_main_data_nxt = '0;
                    w_main_ctrl_nxt = CTRL_NOP;
                    w_skid_data_nxt = '0;
                    w_skid_ctrl_nxt = CTRL_NOP;
                end
            endcase
        end

        w_in_ready_nxt = (w_state_nxt != OCC_FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= OCC_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= CTRL_NOP;
            r_skid_data <= '0;
            r_skid_ctrl <= CTRL_NOP;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_data_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            r_in_ready  <= w_in_ready_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;
    assign occ       = occ_count(r_state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid and a non-skid instance share stimulus, each with its
// own FIFO scoreboard of accepted entries compared against the outputs every cycle.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam logic [CW-1:0] NOP = 8'h3C;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;

    logic          in_ready_s, out_valid_s, in_ready_n, out_valid_n;
    logic [DW-1:0] out_data_s, out_data_n;
    logic [CW-1:0] out_ctrl_s, out_ctrl_n;
    logic [1:0]    occ_s, occ_n;

    ent_t q_s[$];
    ent_t q_n[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_deliv_s = 0, exp_deliv_n = 0;
    int   dut_deliv_s = 0, dut_deliv_n = 0;
    logic c_seen = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_ctrl(out_ctrl_s), .occ(occ_s)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(0)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
        .out_ctrl(out_ctrl_n), .occ(occ_n)
    );

    function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
        return d[7:0] ^ 8'hA5;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        ent_t es, en;
        es = (q_s.size() != 0) ? q_s[0] : ent_t'{d: '0, c: NOP};
        en = (q_n.size() != 0) ? q_n[0] : ent_t'{d: '0, c: NOP};
        chk("s_valid", 64'(out_valid_s), 64'(q_s.size() != 0));
        chk("s_data",  64'(out_data_s),  64'(es.d));
        chk("s_ctrl",  64'(out_ctrl_s),  64'(es.c));
        chk("s_occ",   64'(occ_s),       64'(q_s.size()));
        chk("s_ready", 64'(in_ready_s),  64'(q_s.size() < 2));
        chk("n_valid", 64'(out_valid_n), 64'(q_n.size() != 0));
        chk("n_data",  64'(out_data_n),  64'(en.d));
        chk("n_ctrl",  64'(out_ctrl_n),  64'(en.c));
        chk("n_occ",   64'(occ_n),       64'(q_n.size()));
        chk("n_ready", 64'(in_ready_n),  64'(q_n.size() == 0 || out_ready));
    endtask

    // Drives one cycle, checks outputs, then advances both scoreboards as the edge will
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
        logic rdy_s, rdy_n, inf, outf;
        ent_t e;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = ctrl_of(d);
        out_ready = ordy;
        flush     = fl;
        #1;
        check_outputs();
        if (out_valid_s && out_ready) begin
            dut_deliv_s++;
            if (out_data_s == 32'hC) c_seen = 1'b1;
        end
        if (out_valid_n && out_ready) dut_deliv_n++;

        e = '{d: d, c: ctrl_of(d)};
        rdy_s = (q_s.size() < 2);
        inf   = iv && rdy_s;
        outf  = (q_s.size() != 0) && ordy;
        if (outf) exp_deliv_s++;
        if (fl) q_s.delete();
        else begin
            if (outf) void'(q_s.pop_front());
            if (inf) q_s.push_back(e);
        end

        rdy_n = (q_n.size() == 0) || ordy;
        inf   = iv && rdy_n;
        outf  = (q_n.size() != 0) && ordy;
        if (outf) exp_deliv_n++;
        if (fl) q_n.delete();
        else begin
            if (outf) void'(q_n.pop_front());
            if (inf) q_n.push_back(e);
        end
    endtask

    initial begin
        int ds, dn;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_ctrl   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            flush     = 1'($urandom_range(0, 1));
            #1;
            check_outputs();
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;

        // Streaming 1..8
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Back-pressure: 0xA then 0xB with out_ready low
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("bp_occ2",  64'(occ_s), 64'd2);
        chk("bp_rdy0",  64'(in_ready_s), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Flush while FULL with 0xC offered
        step(1'b1, 32'hA1, 1'b0, 1'b0);
        step(1'b1, 32'hA2, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("fl_occ0",  64'(occ_s), 64'd0);
        chk("fl_ctrl",  64'(out_ctrl_s), 64'(NOP));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("fl_no_c",  64'(c_seen), 64'd0);

        // Flush together with out_fire
        step(1'b1, 32'h55, 1'b0, 1'b0);
        ds = dut_deliv_s; dn = dut_deliv_n;
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("flo_s_once", 64'(dut_deliv_s - ds), 64'd1);
        chk("flo_n_once", 64'(dut_deliv_n - dn), 64'd1);

        // Non-skid combinational ready
        step(1'b1, 32'h66, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b0, 1'b0);
        chk("ns_rdy_bp", 64'(in_ready_n), 64'd0);
        step(1'b1, 32'h77, 1'b1, 1'b0);
        chk("ns_rdy_go", 64'(in_ready_n), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("ns_loaded", 64'(out_data_n), 64'h77);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Async reset mid-transfer
        step(1'b1, 32'h91, 1'b0, 1'b0);
        step(1'b1, 32'h92, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h93; in_ctrl = ctrl_of(32'h93); out_ready = 1'b0;
        #2 rst = 1'b0;
        q_s.delete(); q_n.delete();
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        chk("deliv_s", 64'(dut_deliv_s), 64'(exp_deliv_s));
        chk("deliv_n", 64'(dut_deliv_n), 64'(exp_deliv_n));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
